// File: rtl/apb_pkg.sv
// Shared APB definitions: default bus widths, the transfer phase encoding
// (also used by the slave side) and a small width helper.
package apb_pkg;

  localparam int APB_ADDR_W = 5;
  localparam int APB_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Index width for a set of n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: combinational grant from the request vector, with a
// registered search-start pointer that advances past each accepted grant.
module rr_arbiter
  import apb_pkg::*;
#(
  parameter int N_REQ = 2,
  localparam int ID_W = idx_width(N_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             en,
  output logic             any,
  output logic [ID_W-1:0]  gnt_id
);

  // Holds (last_grant + 1) mod N_REQ, so zero after reset favours requester 0.
  logic [ID_W-1:0]    start_ptr;
  logic [2*N_REQ-1:0] rot;
  int                 sum;

  assign rot = {req, req} >> start_ptr;

  always_comb begin
    any    = 1'b0;
    gnt_id = '0;
    sum    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!any && rot[k]) begin
        any = 1'b1;
        sum = int'(start_ptr) + k;
        if (sum >= N_REQ) sum = sum - N_REQ;
        gnt_id = ID_W'(sum);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_ptr <= '0;
    end else if (en && any) begin
      start_ptr <= (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Multi-requester APB master: round-robin grant, one SETUP/ACCESS transfer per
// grant, bounded wait on pready, and a one-cycle response to the served requester.
module apb_req_arbiter
  import apb_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int ADDR_W   = APB_ADDR_W,
  parameter int DATA_W   = APB_DATA_W,
  parameter int WAIT_MAX = 15,
  localparam int ID_W    = idx_width(N_REQ),
  localparam int WCW     = $clog2(WAIT_MAX + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_write,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        req_ack,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    rsp_err,
  output logic                    busy,
  output logic [ADDR_W-1:0]       paddr,
  output logic                    pwrite,
  output logic                    psel,
  output logic                    penable,
  output logic [DATA_W-1:0]       pwdata,
  input  logic [DATA_W-1:0]       prdata,
  input  logic                    pready
);

  localparam logic [WCW-1:0] WAIT_LIM = WCW'(WAIT_MAX);

  apb_state_e      state;
  logic [ID_W-1:0] gnt_id;
  logic [ID_W-1:0] arb_id;
  logic            arb_any;
  logic [WCW-1:0]  wait_cnt;
  logic            done;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .clk    (clk),
    .reset  (reset),
    .req    (req_valid),
    .en     (state == IDLE),
    .any    (arb_any),
    .gnt_id (arb_id)
  );

  // A transfer ends on slave ready or once the wait budget is spent.
  assign done = (state == ACCESS) && (pready || (wait_cnt == WAIT_LIM));
  assign busy = (state != IDLE);

  always_comb begin
    req_ack = '0;
    if (done) req_ack[gnt_id] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      gnt_id    <= '0;
      wait_cnt  <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      rsp_id    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_any) begin
            state  <= SETUP;
            psel   <= 1'b1;
            gnt_id <= arb_id;
            paddr  <= req_addr[arb_id*ADDR_W +: ADDR_W];
            pwdata <= req_wdata[arb_id*DATA_W +: DATA_W];
            pwrite <= req_write[arb_id];
          end
        end
        SETUP: begin
          state    <= ACCESS;
          penable  <= 1'b1;
          wait_cnt <= '0;
        end
        ACCESS: begin
          if (done) begin
            state     <= IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_id    <= gnt_id;
            rsp_err   <= !pready;
            rsp_rdata <= (pready && !pwrite) ? prdata : '0;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          psel    <= 1'b0;
          penable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: transfer-level model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_apb_req_arbiter;

  localparam int N  = 2;
  localparam int AW = 5;
  localparam int DW = 8;
  localparam int WM = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid, req_write, req_ack;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic          rsp_valid, rsp_err, busy;
  logic [0:0]    rsp_id;
  logic [DW-1:0] rsp_rdata, pwdata, prdata;
  logic [AW-1:0] paddr;
  logic          pwrite, psel, penable, pready;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [32];

  always #5 clk = ~clk;

  apb_req_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .WAIT_MAX(WM)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy), .paddr(paddr), .pwrite(pwrite), .psel(psel),
    .penable(penable), .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  // Simple memory slave
  assign prdata = mem[paddr];
  always @(posedge clk) if (psel && penable && pready && pwrite) mem[paddr] <= pwdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int start);
    for (int k = 0; k < N; k++) if (v[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  // Transfer-level model: phase = cycles since grant (0 idle, 1 setup, 2+ access)
  int            phase, prio, m_id, pick;
  logic [AW-1:0] m_addr;
  logic          m_wr;
  logic [DW-1:0] m_wdata;
  logic          m_rsp_v, m_rsp_err;
  int            m_rsp_id;
  logic [DW-1:0] m_rsp_rdata;

  assign pick = rr_pick(req_valid, prio);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= 0; prio <= 0; m_id <= 0; m_addr <= '0; m_wr <= 1'b0; m_wdata <= '0;
      m_rsp_v <= 1'b0; m_rsp_err <= 1'b0; m_rsp_id <= 0; m_rsp_rdata <= '0;
    end else begin
      m_rsp_v <= 1'b0;
      if (phase == 0) begin
        if (pick >= 0) begin
          phase   <= 1;
          m_id    <= pick;
          prio    <= (pick + 1) % N;
          m_addr  <= req_addr[pick*AW +: AW];
          m_wdata <= req_wdata[pick*DW +: DW];
          m_wr    <= req_write[pick];
        end
      end else if (phase == 1) begin
        phase <= 2;
      end else if (pready || (phase - 2 == WM)) begin
        phase       <= 0;
        m_rsp_v     <= 1'b1;
        m_rsp_id    <= m_id;
        m_rsp_err   <= !pready;
        m_rsp_rdata <= (pready && !m_wr) ? prdata : '0;
      end else begin
        phase <= phase + 1;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("psel", 32'(psel), 32'(phase >= 1));
    chk("penable", 32'(penable), 32'(phase >= 2));
    chk("busy", 32'(busy), 32'(phase != 0));
    chk("paddr", 32'(paddr), 32'(m_addr));
    chk("pwrite", 32'(pwrite), 32'(m_wr));
    chk("pwdata", 32'(pwdata), 32'(m_wdata));
    chk("req_ack", 32'(req_ack),
        32'((phase >= 2 && (pready || phase - 2 == WM)) ? (1 << m_id) : 0));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_v));
    if (m_rsp_v) begin
      chk("rsp_id", 32'(rsp_id), 32'(m_rsp_id));
      chk("rsp_err", 32'(rsp_err), 32'(m_rsp_err));
      chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rsp_rdata));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int order[$];
  int ack_at;

  initial begin
    reset = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; pready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_psel", 32'(psel), 0);
    chk("rst_penable", 32'(penable), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_paddr", 32'(paddr), 0);
    @(negedge clk) reset = 1'b0;
    step();

    // Write from requester 0, zero-wait slave
    req_valid = 2'b01; req_write[0] = 1'b1; req_addr[4:0] = 5'h05; req_wdata[7:0] = 8'hA5;
    step();
    chk("t1_setup_psel", 32'(psel), 1);
    chk("t1_setup_penable", 32'(penable), 0);
    chk("t1_setup_ack", 32'(req_ack), 0);
    step();
    chk("t1_acc_penable", 32'(penable), 1);
    chk("t1_acc_ack", 32'(req_ack), 32'h1);
    chk("t1_paddr", 32'(paddr), 32'h05);
    chk("t1_pwrite", 32'(pwrite), 1);
    chk("t1_pwdata", 32'(pwdata), 32'hA5);
    step();
    chk("t1_rsp_valid", 32'(rsp_valid), 1);
    chk("t1_rsp_id", 32'(rsp_id), 0);
    chk("t1_rsp_err", 32'(rsp_err), 0);
    chk("t1_idle_psel", 32'(psel), 0);
    req_valid = 2'b00;

    // Read back from requester 1
    req_valid = 2'b10; req_write[1] = 1'b0; req_addr[9:5] = 5'h05;
    step();
    step();
    chk("t2_ack", 32'(req_ack), 32'h2);
    chk("t2_pwrite", 32'(pwrite), 0);
    step();
    chk("t2_rsp_valid", 32'(rsp_valid), 1);
    chk("t2_rsp_rdata", 32'(rsp_rdata), 32'hA5);
    chk("t2_rsp_id", 32'(rsp_id), 1);
    req_valid = 2'b00;

    // Both requesting continuously: grants alternate, one idle cycle between
    req_write = 2'b01; req_addr = {5'h05, 5'h01}; req_wdata[7:0] = 8'h11;
    req_valid = 2'b11;
    for (int c = 0; c < 12; c++) begin
      step();
      if (req_ack != '0) order.push_back(int'(req_ack[1]));
      chk("t3_psel_pattern", 32'(psel), 32'((c % 3) != 2));
    end
    chk("t3_grant_count", 32'(order.size()), 4);
    if (order.size() == 4) begin
      chk("t3_grant0", 32'(order[0]), 0);
      chk("t3_grant1", 32'(order[1]), 1);
      chk("t3_grant2", 32'(order[2]), 0);
      chk("t3_grant3", 32'(order[3]), 1);
    end
    chk("t3_last_rdata", 32'(rsp_rdata), 32'hA5);
    req_valid = 2'b00;

    // Three wait states, then ready
    req_valid = 2'b01; req_write = 2'b01; req_addr[4:0] = 5'h0A; req_wdata[7:0] = 8'h3C;
    pready = 1'b0;
    step();
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("t4_wait_ack", 32'(req_ack), 0);
      chk("t4_wait_penable", 32'(penable), 1);
      chk("t4_wait_paddr", 32'(paddr), 32'h0A);
      chk("t4_wait_pwdata", 32'(pwdata), 32'h3C);
    end
    step();
    pready = 1'b1;
    #1;
    chk("t4_ack", 32'(req_ack), 32'h1);
    chk("t4_paddr", 32'(paddr), 32'h0A);
    step();
    chk("t4_rsp_valid", 32'(rsp_valid), 1);
    chk("t4_rsp_err", 32'(rsp_err), 0);
    req_valid = 2'b00;

    // Slave never ready: abort on the 16th access cycle
    req_valid = 2'b10; req_write = 2'b00; req_addr[9:5] = 5'h03; pready = 1'b0;
    step();
    ack_at = 0;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (req_ack != '0 && ack_at == 0) ack_at = i;
    end
    chk("t5_abort_cycle", 32'(ack_at), 16);
    chk("t5_abort_ack", 32'(req_ack), 32'h2);
    step();
    chk("t5_rsp_valid", 32'(rsp_valid), 1);
    chk("t5_rsp_err", 32'(rsp_err), 1);
    chk("t5_rsp_rdata", 32'(rsp_rdata), 0);
    chk("t5_rsp_id", 32'(rsp_id), 1);
    chk("t5_busy", 32'(busy), 0);
    req_valid = 2'b00; pready = 1'b1;

    // Reset in the middle of an access
    req_valid = 2'b01; req_write = 2'b01; req_addr = {5'h03, 5'h07}; req_wdata[7:0] = 8'h77;
    pready = 1'b0;
    step();
    step();
    chk("t6_pre_penable", 32'(penable), 1);
    reset = 1'b1; req_valid = 2'b11;
    #1;
    chk("t6_rst_psel", 32'(psel), 0);
    chk("t6_rst_penable", 32'(penable), 0);
    chk("t6_rst_rsp_valid", 32'(rsp_valid), 0);
    chk("t6_rst_ack", 32'(req_ack), 0);
    step();
    step();
    chk("t6_rst_no_rsp", 32'(rsp_valid), 0);
    @(negedge clk) reset = 1'b0; pready = 1'b1;
    step();
    chk("t6_first_paddr", 32'(paddr), 32'h07);
    step();
    chk("t6_first_ack", 32'(req_ack), 32'h1);
    step();
    chk("t6_rsp_id", 32'(rsp_id), 0);
    req_valid = 2'b00;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
Multi-requester APB master. Arbitrates round-robin between N_REQ internal requesters and sequences each granted request as one APB transfer (IDLE -> SETUP -> ACCESS) to the single 8-bit-data, 5-bit-address APB memory slave. Returns read data or a timeout error to the requester that was served. Sits between the control/DMA logic and the APB slave port.

Parameters:
N_REQ, 2, number of requesters (2..8)
ADDR_W, 5, APB address width
DATA_W, 8, APB data width
WAIT_MAX, 15, max ACCESS cycles with pready low before abort (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  N_REQ  per-requester request; held with fields until req_ack
req_write  in  N_REQ  per-requester 1=write, 0=read
req_addr  in  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  N_REQ*DATA_W  packed write data
req_ack  out  N_REQ  one-hot, combinational; transfer completes on the edge where it is high
rsp_valid  out  1  registered, 1-cycle pulse the cycle after completion
rsp_id  out  $clog2(N_REQ) (min 1)  requester index of this response
rsp_rdata  out  DATA_W  read data (0 for writes and errors), valid with rsp_valid
rsp_err  out  1  timeout abort, valid with rsp_valid
busy  out  1  high when state != IDLE
paddr  out  ADDR_W  APB address
pwrite  out  1  APB direction
psel  out  1  APB select
penable  out  1  APB enable
pwdata  out  DATA_W  APB write data
prdata  in  DATA_W  APB read data
pready  in  1  APB ready

Behaviour:
- Reset (async): state=IDLE, psel=penable=pwrite=0, paddr=pwdata=0, rsp_valid=rsp_err=0, rsp_rdata=0, rsp_id=0, wait_cnt=0, rr pointer=0 (requester 0 highest priority). Reset mid-transfer drops psel/penable immediately; no ack or response is issued for the aborted transfer.
- States: IDLE, SETUP, ACCESS. psel=1 in SETUP and ACCESS; penable=1 only in ACCESS.
- IDLE: if any req_valid at the edge, grant one round-robin: search starts at (last_grant+1) mod N_REQ. Latch addr/write/wdata/id into paddr/pwrite/pwdata/gnt_id. Go to SETUP. Otherwise stay.
- SETUP: unconditional -> ACCESS; wait_cnt cleared.
- ACCESS, pready=1: req_ack[gnt_id]=1 this cycle. Next edge -> IDLE; rsp_valid=1, rsp_id=gnt_id, rsp_err=0, rsp_rdata=prdata for reads, 0 for writes.
- ACCESS, pready=0, wait_cnt<WAIT_MAX: stay; wait_cnt++. APB outputs hold stable.
- ACCESS, pready=0, wait_cnt==WAIT_MAX: abort. req_ack[gnt_id]=1 this cycle. Next edge -> IDLE; rsp_valid=1, rsp_err=1, rsp_rdata=0.
- Latency with zero-wait slave: request sampled at edge E0 -> SETUP E0-E1 -> ACCESS/ack E1-E2 -> rsp_valid E2-E3. One transfer every 3 cycles. The mandatory IDLE cycle after each transfer gives psel=0 for one cycle and lets requesters update req_valid.
- Pointer (last_grant) updates on grant only. A requester whose req_valid is continuously high is served within N_REQ transfers.
- A requester may drop req_valid before it is granted; the request is then withdrawn. After grant, the latched copy is used; input changes are ignored.
- req_ack is never high in IDLE/SETUP and is never high for more than one requester.
- wait_cnt width is $clog2(WAIT_MAX+1); it never wraps.

Decomposition:
- Package apb_pkg: ADDR_W/DATA_W defaults; apb_state_e enum {IDLE, SETUP, ACCESS} (2-bit), shared with the slave.
- Sub-module rr_arbiter (N_REQ): combinational grant from req vector and last_grant, registered last_grant update on grant enable. The rest (FSM, latch, timeout, response) stays in apb_req_arbiter.

Test Plan:
- Write req0 addr 5'h05 data 8'hA5, pready=1 -> psel high cycle 1, penable+req_ack[0] cycle 2, paddr=05 pwrite=1 pwdata=A5; rsp_valid cycle 3, rsp_id=0, rsp_err=0.
- Read req1 addr 5'h05 after the above -> slave returns A5; rsp_valid with rsp_rdata=8'hA5, rsp_id=1.
- req_valid=2'b11 held continuously from reset -> grants alternate 0,1,0,1; psel low exactly one cycle between transfers.
- pready low for 3 ACCESS cycles then high -> req_ack on 4th ACCESS cycle, rsp_err=0, paddr/pwdata stable throughout.
- pready held low -> abort on 16th ACCESS cycle (WAIT_MAX=15): req_ack pulse, then rsp_err=1, rsp_rdata=0; return to IDLE.
- Assert reset during ACCESS -> psel/penable/rsp_valid 0 immediately, no req_ack; after release with req_valid=2'b11, requester 0 is granted first.
